// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and width helpers for the shared-register arbiter and its picker.
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter; slave is the arbiter.
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int IDW = id_width(N)
) ();

  logic [N-1:0]   req_i;
  logic [N-1:0]   rel_i;
  logic [N-1:0]   wr_en_i;
  logic [N*W-1:0] wdata_i;
  logic [N-1:0]   grant_o;
  logic [IDW-1:0] owner_id_o;
  logic           busy_o;
  logic [W-1:0]   q_o;
  logic           timeout_o;
  logic           viol_o;

  modport slave (
    input  req_i, rel_i, wr_en_i, wdata_i,
    output grant_o, owner_id_o, busy_o, q_o, timeout_o, viol_o
  );

  modport master (
    output req_i, rel_i, wr_en_i, wdata_i,
    input  grant_o, owner_id_o, busy_o, q_o, timeout_o, viol_o
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... mod N.
module shared_reg_arbiter_rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = id_width(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           any_o,
  output logic [IDW-1:0] sel_o
);

  // Scan from the far end so the candidate nearest ptr is written last and wins.
  always_comb begin
    int idx;
    idx   = 0;
    any_o = 1'b0;
    sel_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (req_i[IDW'(idx)]) begin
        any_o = 1'b1;
        sel_o = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner arbitration, hold-time limit and load control for one shared W-bit register.
//   state | meaning
//   IDLE  | no owner; arbitrate pending requests from ptr
//   OWN   | one requester holds the register and may write it
//   TURN  | mandatory one-cycle gap after ownership ends
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int            N         = 4,
  parameter int            W         = 8,
  parameter int            HOLD_MAX  = 16,
  parameter logic [W-1:0]  RESET_VAL = '0,
  localparam int           IDW       = id_width(N),
  localparam int           CW        = id_width(HOLD_MAX)
) (
  input logic                          clk,
  input logic                          reset,
  shared_reg_arbiter_if.slave          bus
);

  state_e         state_q;
  logic [N-1:0]   grant_q;
  logic [IDW-1:0] owner_q;
  logic [IDW-1:0] ptr_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic [W-1:0]   q_q;
  logic           timeout_q;
  logic           viol_q;

  logic           any;
  logic [IDW-1:0] sel;
  logic           last_slot;
  logic           owner_rel;
  logic           own_end;

  shared_reg_arbiter_rr_pick #(.N(N)) u_pick (
    .req_i (bus.req_i),
    .ptr_i (ptr_q),
    .any_o (any),
    .sel_o (sel)
  );

  assign last_slot = (cnt_q == CW'(HOLD_MAX - 1));
  assign owner_rel = bus.rel_i[owner_q] | ~bus.req_i[owner_q];
  assign own_end   = owner_rel | last_slot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      q_q       <= RESET_VAL;
      timeout_q <= 1'b0;
      viol_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      viol_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any) begin
            grant_q      <= '0;
            grant_q[sel] <= 1'b1;
            owner_q      <= sel;
            busy_q       <= 1'b1;
            cnt_q        <= '0;
            state_q      <= OWN;
          end
        end
        OWN: begin
          if (bus.wr_en_i[owner_q]) q_q <= bus.wdata_i[owner_q*W +: W];
          if (|(bus.wr_en_i & ~grant_q)) viol_q <= 1'b1;
          if (own_end) begin
            // An explicit release in the last permitted cycle is not a timeout.
            timeout_q <= last_slot & ~owner_rel;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            owner_q   <= '0;
            ptr_q     <= (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
            state_q   <= TURN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TURN:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant_o    = grant_q;
  assign bus.owner_id_o = owner_q;
  assign bus.busy_o     = busy_q;
  assign bus.q_o        = q_q;
  assign bus.timeout_o  = timeout_q;
  assign bus.viol_o     = viol_q;

endmodule
